// File: rtl/riscv_core_pipe_pkg.sv
// Shared ID->EX pipeline definitions: packed bundle layout, memop/branch
// encodings, the bubble control-field mask and the load classifier.
package riscv_core_pipe_pkg;

    localparam int PIPE_XLEN     = 32;
    localparam int PIPE_BUNDLE_W = 193;

    // Bundle layout, LSB first: five XLEN data words, register indices, then controls.
    localparam int PC_LSB        = 0;
    localparam int INSTR_LSB     = 32;
    localparam int IMMED_LSB     = 64;
    localparam int REG1_LSB      = 96;
    localparam int REG2_LSB      = 128;
    localparam int RD_LSB        = 160;
    localparam int RS1_LSB       = 165;
    localparam int RS2_LSB       = 170;
    localparam int ALUOP_LSB     = 175;
    localparam int ALUSRC1_LSB   = 179;
    localparam int ALUSRC2_LSB   = 180;
    localparam int RFWT_SEL_LSB  = 181;
    localparam int REGWRITE_LSB  = 183;
    localparam int MEMOP_LSB     = 184;
    localparam int BRANCHOP_LSB  = 188;
    localparam int BRNCH_SEL_LSB = 191;

    localparam int REG_IDX_W     = 5;
    localparam int MEMOP_W       = 4;
    localparam int BRANCHOP_W    = 3;
    localparam int BRNCH_SEL_W   = 2;

    localparam logic [MEMOP_W-1:0] MEMOP_NONE = 4'd0;
    localparam logic [MEMOP_W-1:0] MEMOP_LB   = 4'd1;
    localparam logic [MEMOP_W-1:0] MEMOP_LH   = 4'd2;
    localparam logic [MEMOP_W-1:0] MEMOP_LW   = 4'd3;
    localparam logic [MEMOP_W-1:0] MEMOP_LBU  = 4'd4;
    localparam logic [MEMOP_W-1:0] MEMOP_LHU  = 4'd5;
    localparam logic [MEMOP_W-1:0] MEMOP_SB   = 4'd8;
    localparam logic [MEMOP_W-1:0] MEMOP_SH   = 4'd9;
    localparam logic [MEMOP_W-1:0] MEMOP_SW   = 4'd10;

    localparam logic [BRANCHOP_W-1:0] BR_NONE = 3'd0;

    function automatic logic [PIPE_BUNDLE_W-1:0] field_mask(input int lsb, input int w);
        logic [PIPE_BUNDLE_W-1:0] ones;
        ones = (PIPE_BUNDLE_W'(1) << w) - PIPE_BUNDLE_W'(1);
        return ones << lsb;
    endfunction

    // Bits cleared to form a bubble; every cleared field's "none" encoding is zero.
    localparam logic [PIPE_BUNDLE_W-1:0] BUBBLE_CTRL_MASK =
          field_mask(RD_LSB,        REG_IDX_W)
        | field_mask(REGWRITE_LSB,  1)
        | field_mask(MEMOP_LSB,     MEMOP_W)
        | field_mask(BRANCHOP_LSB,  BRANCHOP_W)
        | field_mask(BRNCH_SEL_LSB, BRNCH_SEL_W);

    function automatic logic is_load(input logic [MEMOP_W-1:0] memop);
        return !memop[3] && (memop != MEMOP_NONE);
    endfunction

endpackage

// File: rtl/riscv_core_ex_hazard_det.sv
// Load-use hazard compare between the instruction in EX and the one in ID.
module riscv_core_ex_hazard_det
    import riscv_core_pipe_pkg::*;
(
    input  logic                 ex_valid,
    input  logic [MEMOP_W-1:0]   ex_memop,
    input  logic                 ex_regwrite,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic                 id_act,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    output logic                 hazard
);

    // rs2 is compared even for I-type instructions; a spurious stall is harmless.
    assign hazard = ex_valid && is_load(ex_memop) && ex_regwrite
                 && (ex_rd != '0) && id_act
                 && ((ex_rd == id_rs1) || (ex_rd == id_rs2));

endmodule

// File: rtl/riscv_core_ex_pipe_reg.sv
// ID/EX register bank with valid bit, stall/flush, load-use bubble insertion
// and a saturating bubble counter.
module riscv_core_ex_pipe_reg
    import riscv_core_pipe_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int BUNDLE_W = 193,
    parameter int CNT_W    = 32
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                id_act,
    input  logic [BUNDLE_W-1:0] id_bundle_D,
    input  logic                ex_stall,
    input  logic                ex_flush,
    output logic [BUNDLE_W-1:0] ex_bundle_Q,
    output logic                ex_valid_Q,
    output logic                id_hold,
    output logic [CNT_W-1:0]    bubble_cnt_Q
);

    if ((XLEN != PIPE_XLEN) || (BUNDLE_W != PIPE_BUNDLE_W)) begin : g_cfg_check
        $error("riscv_core_ex_pipe_reg: XLEN/BUNDLE_W must match riscv_core_pipe_pkg layout");
    end

    logic [BUNDLE_W-1:0] ex_bundle_d, ex_bundle_q, bubble_bundle;
    logic                ex_valid_d, ex_valid_q;
    logic [CNT_W-1:0]    bubble_cnt_d, bubble_cnt_q;
    logic                hazard;

    riscv_core_ex_hazard_det u_hazard_det (
        .ex_valid    (ex_valid_q),
        .ex_memop    (ex_bundle_q[MEMOP_LSB +: MEMOP_W]),
        .ex_regwrite (ex_bundle_q[REGWRITE_LSB]),
        .ex_rd       (ex_bundle_q[RD_LSB +: REG_IDX_W]),
        .id_act      (id_act),
        .id_rs1      (id_bundle_D[RS1_LSB +: REG_IDX_W]),
        .id_rs2      (id_bundle_D[RS2_LSB +: REG_IDX_W]),
        .hazard      (hazard)
    );

    // Data fields keep their last value so a bubble does not toggle the EX datapath.
    assign bubble_bundle = ex_bundle_q & ~BUBBLE_CTRL_MASK;

    always_comb begin
        // NOTE: defaults first so every path assigns every signal -- no latches.
        ex_bundle_d  = ex_bundle_q;
        ex_valid_d   = ex_valid_q;
        bubble_cnt_d = bubble_cnt_q;
        if (ex_flush) begin
            ex_bundle_d = bubble_bundle;
            ex_valid_d  = 1'b0;
        end else if (ex_stall) begin
            ex_bundle_d = ex_bundle_q;
        end else if (hazard) begin
            ex_bundle_d = bubble_bundle;
            ex_valid_d  = 1'b0;
            if (!(&bubble_cnt_q)) begin
                bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
            end
        end else if (id_act) begin
            ex_bundle_d = id_bundle_D;
            ex_valid_d  = 1'b1;
        end else begin
            ex_bundle_d = bubble_bundle;
            ex_valid_d  = 1'b0;
        end
    end

    // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ex_bundle_q  <= '0;
            ex_valid_q   <= 1'b0;
            bubble_cnt_q <= '0;
        end else begin
            ex_bundle_q  <= ex_bundle_d;
            ex_valid_q   <= ex_valid_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign id_hold      = hazard && !ex_flush && !ex_stall;
    assign ex_bundle_Q  = ex_bundle_q;
    assign ex_valid_Q   = ex_valid_q;
    assign bubble_cnt_Q = bubble_cnt_q;

endmodule

// File: tb/tb_riscv_core_ex_pipe_reg.sv
// Directed bench for the ID/EX register: reset, pass-through, load-use bubbles,
// false-hazard filtering, stall/flush priority and counter saturation.
module tb_riscv_core_ex_pipe_reg;

    localparam int BW = 193;
    localparam int CW = 4;

    logic          CLK, RST, id_act, ex_stall, ex_flush;
    logic [BW-1:0] id_bundle_D, ex_bundle_Q;
    logic          ex_valid_Q, id_hold;
    logic [CW-1:0] bubble_cnt_Q;

    int            n_cmp = 0;
    int            n_bad = 0;
    logic [CW-1:0] exp_cnt = '0;

    riscv_core_ex_pipe_reg #(.XLEN(32), .BUNDLE_W(BW), .CNT_W(CW)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .id_act       (id_act),
        .id_bundle_D  (id_bundle_D),
        .ex_stall     (ex_stall),
        .ex_flush     (ex_flush),
        .ex_bundle_Q  (ex_bundle_Q),
        .ex_valid_Q   (ex_valid_Q),
        .id_hold      (id_hold),
        .bubble_cnt_Q (bubble_cnt_Q)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    // Independent packing: {brnch_sel,branchop,memop,regwrite,rfwt_sel,alusrc2,alusrc1,aluop,rs2,rs1,rd,reg2,reg1,immed,instr,pc}
    function automatic logic [BW-1:0] mk(input logic [31:0] pc, input logic [31:0] instr,
                                         input logic [4:0] rd, input logic [4:0] rs1,
                                         input logic [4:0] rs2, input logic [3:0] memop,
                                         input logic regwrite, input logic [2:0] branchop,
                                         input logic [1:0] brnch_sel);
        return {brnch_sel, branchop, memop, regwrite, 2'd2, 1'b0, 1'b1, pc[3:0] ^ 4'h9,
                rs2, rs1, rd, ~pc, instr + 32'd1, pc ^ 32'h5a5a_0000, instr, pc};
    endfunction

    // Same instruction with its control fields cleared, data fields kept.
    function automatic logic [BW-1:0] bub(input logic [31:0] pc, input logic [31:0] instr,
                                          input logic [4:0] rs1, input logic [4:0] rs2);
        return mk(pc, instr, 5'd0, rs1, rs2, 4'd0, 1'b0, 3'd0, 2'd0);
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b0; id_act = 1'b0; ex_stall = 1'b0; ex_flush = 1'b0; id_bundle_D = '0;
        #2;
        n_cmp++; if (ex_valid_Q !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", ex_valid_Q); end
        n_cmp++; if (ex_bundle_Q !== '0) begin n_bad++; $display("FAIL reset_bundle: got %h want 0", ex_bundle_Q); end
        n_cmp++; if (bubble_cnt_Q !== '0) begin n_bad++; $display("FAIL reset_cnt: got %h want 0", bubble_cnt_Q); end
        n_cmp++; if (id_hold !== 1'b0) begin n_bad++; $display("FAIL reset_hold: got %b want 0", id_hold); end
        step(); step();
        @(negedge CLK) RST = 1'b1;
        step();
    endtask

    task automatic test_reset_mid_op();
        id_act = 1'b1;
        id_bundle_D = mk(32'h40, 32'h0002_a283, 5'd5, 5'd1, 5'd0, 4'd3, 1'b1, 3'd0, 2'd0);
        step();
        n_cmp++; if (ex_valid_Q !== 1'b1) begin n_bad++; $display("FAIL midrst_pre_valid: got %b want 1", ex_valid_Q); end
        id_bundle_D = mk(32'h44, 32'h0012_8333, 5'd6, 5'd5, 5'd1, 4'd0, 1'b1, 3'd0, 2'd0);
        #1;
        n_cmp++; if (id_hold !== 1'b1) begin n_bad++; $display("FAIL midrst_pre_hold: got %b want 1", id_hold); end
        #1 RST = 1'b0;
        #1;
        n_cmp++; if (ex_valid_Q !== 1'b0) begin n_bad++; $display("FAIL midrst_valid: got %b want 0", ex_valid_Q); end
        n_cmp++; if (ex_bundle_Q !== '0) begin n_bad++; $display("FAIL midrst_bundle: got %h want 0", ex_bundle_Q); end
        n_cmp++; if (bubble_cnt_Q !== '0) begin n_bad++; $display("FAIL midrst_cnt: got %h want 0", bubble_cnt_Q); end
        n_cmp++; if (id_hold !== 1'b0) begin n_bad++; $display("FAIL midrst_hold: got %b want 0", id_hold); end
        #1 RST = 1'b1;
        id_act = 1'b0;
        exp_cnt = '0;
        step();
    endtask

    task automatic test_pass_through();
        logic [BW-1:0] e;
        e = mk(32'h100, 32'h0020_81b3, 5'd3, 5'd1, 5'd2, 4'd0, 1'b1, 3'd0, 2'd0);
        id_act = 1'b1; id_bundle_D = e;
        step();
        n_cmp++; if (ex_bundle_Q[31:0] !== 32'h100) begin n_bad++; $display("FAIL pass_pc: got %h want 100", ex_bundle_Q[31:0]); end
        n_cmp++; if (ex_bundle_Q[164:160] !== 5'd3) begin n_bad++; $display("FAIL pass_rd: got %0d want 3", ex_bundle_Q[164:160]); end
        n_cmp++; if (ex_bundle_Q !== e) begin n_bad++; $display("FAIL pass_bundle: got %h want %h", ex_bundle_Q, e); end
        n_cmp++; if (ex_valid_Q !== 1'b1) begin n_bad++; $display("FAIL pass_valid: got %b want 1", ex_valid_Q); end
    endtask

    task automatic test_load_use();
        logic [BW-1:0] add_b;
        id_act = 1'b1;
        id_bundle_D = mk(32'h200, 32'h0000_a383, 5'd7, 5'd1, 5'd0, 4'd3, 1'b1, 3'd0, 2'd0);
        step();
        add_b = mk(32'h204, 32'h0071_0433, 5'd8, 5'd2, 5'd7, 4'd0, 1'b1, 3'd0, 2'd0);
        id_bundle_D = add_b;
        #1;
        n_cmp++; if (id_hold !== 1'b1) begin n_bad++; $display("FAIL lu_hold: got %b want 1", id_hold); end
        step();
        exp_cnt = exp_cnt + 4'd1;
        n_cmp++; if (ex_valid_Q !== 1'b0) begin n_bad++; $display("FAIL lu_bub_valid: got %b want 0", ex_valid_Q); end
        n_cmp++; if (ex_bundle_Q[183] !== 1'b0) begin n_bad++; $display("FAIL lu_bub_regwrite: got %b want 0", ex_bundle_Q[183]); end
        n_cmp++; if (ex_bundle_Q !== bub(32'h200, 32'h0000_a383, 5'd1, 5'd0)) begin
            n_bad++; $display("FAIL lu_bub_bundle: got %h want %h", ex_bundle_Q, bub(32'h200, 32'h0000_a383, 5'd1, 5'd0)); end
        n_cmp++; if (bubble_cnt_Q !== exp_cnt) begin n_bad++; $display("FAIL lu_cnt: got %0d want %0d", bubble_cnt_Q, exp_cnt); end
        n_cmp++; if (id_hold !== 1'b0) begin n_bad++; $display("FAIL lu_hold_drop: got %b want 0", id_hold); end
        step();
        n_cmp++; if (ex_bundle_Q !== add_b) begin n_bad++; $display("FAIL lu_add_bundle: got %h want %h", ex_bundle_Q, add_b); end
        n_cmp++; if (ex_valid_Q !== 1'b1) begin n_bad++; $display("FAIL lu_add_valid: got %b want 1", ex_valid_Q); end
    endtask

    task automatic test_no_false_hazard();
        logic [BW-1:0] add_b;
        id_act = 1'b1;
        id_bundle_D = mk(32'h300, 32'h0000_a003, 5'd0, 5'd1, 5'd0, 4'd3, 1'b1, 3'd0, 2'd0);
        step();
        add_b = mk(32'h304, 32'h0000_04b3, 5'd9, 5'd0, 5'd0, 4'd0, 1'b1, 3'd0, 2'd0);
        id_bundle_D = add_b;
        #1;
        n_cmp++; if (id_hold !== 1'b0) begin n_bad++; $display("FAIL nf_x0_hold: got %b want 0", id_hold); end
        step();
        n_cmp++; if (ex_bundle_Q !== add_b || ex_valid_Q !== 1'b1) begin
            n_bad++; $display("FAIL nf_x0_pass: got %h/%b want %h/1", ex_bundle_Q, ex_valid_Q, add_b); end
        id_bundle_D = mk(32'h308, 32'h0070_a023, 5'd7, 5'd1, 5'd7, 4'd10, 1'b1, 3'd0, 2'd0);
        step();
        add_b = mk(32'h30c, 32'h0003_8533, 5'd10, 5'd7, 5'd3, 4'd0, 1'b1, 3'd0, 2'd0);
        id_bundle_D = add_b;
        #1;
        n_cmp++; if (id_hold !== 1'b0) begin n_bad++; $display("FAIL nf_sw_hold: got %b want 0", id_hold); end
        step();
        n_cmp++; if (ex_bundle_Q !== add_b || ex_valid_Q !== 1'b1) begin
            n_bad++; $display("FAIL nf_sw_pass: got %h/%b want %h/1", ex_bundle_Q, ex_valid_Q, add_b); end
        n_cmp++; if (bubble_cnt_Q !== exp_cnt) begin n_bad++; $display("FAIL nf_cnt: got %0d want %0d", bubble_cnt_Q, exp_cnt); end
    endtask

    task automatic test_stall_flush();
        logic [BW-1:0] x_b, y_b;
        x_b = mk(32'h400, 32'h0000_a483, 5'd9, 5'd1, 5'd0, 4'd3, 1'b1, 3'd0, 2'd0);
        y_b = mk(32'h404, 32'h0004_8593, 5'd11, 5'd9, 5'd0, 4'd0, 1'b1, 3'd0, 2'd0);
        id_act = 1'b1; id_bundle_D = x_b;
        step();
        ex_stall = 1'b1; id_bundle_D = y_b;
        #1;
        n_cmp++; if (id_hold !== 1'b0) begin n_bad++; $display("FAIL sf_stall_hold: got %b want 0", id_hold); end
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++; if (ex_bundle_Q !== x_b || ex_valid_Q !== 1'b1) begin
                n_bad++; $display("FAIL sf_stall_%0d: got %h/%b want %h/1", i, ex_bundle_Q, ex_valid_Q, x_b); end
        end
        n_cmp++; if (bubble_cnt_Q !== exp_cnt) begin n_bad++; $display("FAIL sf_stall_cnt: got %0d want %0d", bubble_cnt_Q, exp_cnt); end
        ex_flush = 1'b1;
        #1;
        n_cmp++; if (id_hold !== 1'b0) begin n_bad++; $display("FAIL sf_flush_hold: got %b want 0", id_hold); end
        step();
        n_cmp++; if (ex_valid_Q !== 1'b0) begin n_bad++; $display("FAIL sf_flush_valid: got %b want 0", ex_valid_Q); end
        n_cmp++; if (ex_bundle_Q !== bub(32'h400, 32'h0000_a483, 5'd1, 5'd0)) begin
            n_bad++; $display("FAIL sf_flush_bundle: got %h want %h", ex_bundle_Q, bub(32'h400, 32'h0000_a483, 5'd1, 5'd0)); end
        n_cmp++; if (bubble_cnt_Q !== exp_cnt) begin n_bad++; $display("FAIL sf_flush_cnt: got %0d want %0d", bubble_cnt_Q, exp_cnt); end
        ex_stall = 1'b0; ex_flush = 1'b0;
        step();
        n_cmp++; if (ex_bundle_Q !== y_b || ex_valid_Q !== 1'b1) begin
            n_bad++; $display("FAIL sf_resume: got %h/%b want %h/1", ex_bundle_Q, ex_valid_Q, y_b); end
        id_act = 1'b0;
        step();
        n_cmp++; if (ex_valid_Q !== 1'b0 || ex_bundle_Q !== bub(32'h404, 32'h0004_8593, 5'd9, 5'd0)) begin
            n_bad++; $display("FAIL sf_idle: got %h/%b want bubble/0", ex_bundle_Q, ex_valid_Q); end
        n_cmp++; if (bubble_cnt_Q !== exp_cnt) begin n_bad++; $display("FAIL sf_idle_cnt: got %0d want %0d", bubble_cnt_Q, exp_cnt); end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 17; i++) begin
            id_act = 1'b1;
            id_bundle_D = mk(32'h500, 32'h0000_a383, 5'd7, 5'd1, 5'd0, 4'd1, 1'b1, 3'd0, 2'd0);
            step();
            id_bundle_D = mk(32'h504, 32'h0071_0433, 5'd8, 5'd2, 5'd7, 4'd0, 1'b1, 3'd0, 2'd0);
            step();
            if (exp_cnt != 4'hF) exp_cnt = exp_cnt + 4'd1;
            n_cmp++; if (bubble_cnt_Q !== exp_cnt) begin
                n_bad++; $display("FAIL sat_cnt_%0d: got %0d want %0d", i, bubble_cnt_Q, exp_cnt); end
        end
        n_cmp++; if (bubble_cnt_Q !== 4'hF) begin n_bad++; $display("FAIL sat_final: got %h want f", bubble_cnt_Q); end
    endtask

    initial begin
        test_reset();
        test_reset_mid_op();
        test_pass_through();
        test_load_use();
        test_no_false_hazard();
        test_stall_flush();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
